comp: RTL and testbench

COMP -- requirements
Module: comp

---
 rtl/comp.sv | 83 ++++++++
 tb/tb_comp.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/comp.sv
// Three-input sorter: registers min/mid/max of (a,b,c) together with the source
// index of each, one cycle after in_valid. Ties resolve by source priority a < b < c.
module comp #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] min,
  output logic [WIDTH-1:0] mid,
  output logic [WIDTH-1:0] max,
  output logic [1:0]       min_idx,
  output logic [1:0]       mid_idx,
  output logic [1:0]       max_idx,
  output logic             out_valid
);

  // Handshake: valid-only, no backpressure. A triple is accepted on every rising
  // edge with in_valid=1; out_valid is high for exactly the following cycle.

  logic [WIDTH-1:0] min_d, min_q, mid_d, mid_q, max_d, max_q;
  logic [1:0]       min_idx_d, min_idx_q, mid_idx_d, mid_idx_q, max_idx_d, max_idx_q;
  logic             out_valid_d, out_valid_q;
  logic [1:0]       rank_a, rank_b, rank_c;

  // Rank = number of operands ordered before this one; an equal operand with a
  // lower source index counts as smaller, so the ranks are always a permutation.
  always_comb begin
    rank_a = {1'b0, (b <  a)} + {1'b0, (c <  a)};
    rank_b = {1'b0, (a <= b)} + {1'b0, (c <  b)};
    rank_c = {1'b0, (a <= c)} + {1'b0, (b <= c)};
  end

  always_comb begin
    min_d       = min_q;
    mid_d       = mid_q;
    max_d       = max_q;
    min_idx_d   = min_idx_q;
    mid_idx_d   = mid_idx_q;
    max_idx_d   = max_idx_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      min_d     = (rank_a == 2'd0) ? a : (rank_b == 2'd0) ? b : c;
      min_idx_d = (rank_a == 2'd0) ? 2'd0 : (rank_b == 2'd0) ? 2'd1 : 2'd2;
      mid_d     = (rank_a == 2'd1) ? a : (rank_b == 2'd1) ? b : c;
      mid_idx_d = (rank_a == 2'd1) ? 2'd0 : (rank_b == 2'd1) ? 2'd1 : 2'd2;
      max_d     = (rank_a == 2'd2) ? a : (rank_b == 2'd2) ? b : c;
      max_idx_d = (rank_a == 2'd2) ? 2'd0 : (rank_b == 2'd2) ? 2'd1 : 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q       <= '0;
      mid_q       <= '0;
      max_q       <= '0;
      min_idx_q   <= 2'd0;
      mid_idx_q   <= 2'd1;
      max_idx_q   <= 2'd2;
      out_valid_q <= 1'b0;
    end else begin
      min_q       <= min_d;
      mid_q       <= mid_d;
      max_q       <= max_d;
      min_idx_q   <= min_idx_d;
      mid_idx_q   <= mid_idx_d;
      max_idx_q   <= max_idx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign min       = min_q;
  assign mid       = mid_q;
  assign max       = max_q;
  assign min_idx   = min_idx_q;
  assign mid_idx   = mid_idx_q;
  assign max_idx   = max_idx_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_comp.sv
// Bench for comp: directed orderings, ties, extremes, hold and reset cases, then a
// random run, all checked against a stable reference sort.
module tb_comp;
  localparam int W  = 7;
  localparam int RW = 3 * W + 6;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b, c;
  logic [W-1:0] min, mid, max;
  logic [1:0]   min_idx, mid_idx, max_idx;
  logic         out_valid;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] held;
  int n_cmp;
  int n_err;

  comp #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .min(min), .mid(mid), .max(max),
    .min_idx(min_idx), .mid_idx(mid_idx), .max_idx(max_idx),
    .out_valid(out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: stable bubble sort of (value, source) pairs.
  function automatic logic [RW-1:0] ref_sort(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] z);
    int vals[3];
    int idx[3];
    int t;
    vals[0] = int'(x); vals[1] = int'(y); vals[2] = int'(z);
    idx[0] = 0; idx[1] = 1; idx[2] = 2;
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < 2 - p; j++)
        if (vals[j] > vals[j+1]) begin
          t = vals[j]; vals[j] = vals[j+1]; vals[j+1] = t;
          t = idx[j];  idx[j]  = idx[j+1];  idx[j+1]  = t;
        end
    return {W'(vals[0]), W'(vals[1]), W'(vals[2]), 2'(idx[0]), 2'(idx[1]), 2'(idx[2])};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {min, mid, max, min_idx, mid_idx, max_idx};
  endfunction

  // driver: present one cycle of input, then check the registered result
  task automatic step(input string tag, input logic v, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] z);
    logic [RW-1:0] e;
    in_valid = v; a = x; b = y; c = z;
    if (v) exp_q.push_back(ref_sort(x, y, z));
    @(posedge clk);
    #1;
    check({tag, "_ov"}, 64'(out_valid), 64'(v));
    if (v) begin
      e = exp_q.pop_front();
      held = e;
    end
    check({tag, "_res"}, 64'(observed()), 64'(held));
  endtask

  logic [RW-1:0] rst_pat;
  logic [W-1:0]  rx, ry, rz;

  function automatic logic [W-1:0] rnd_val();
    int s;
    s = $urandom_range(0, 9);
    if (s == 0) return '0;
    if (s == 1) return {W{1'b1}};
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  initial begin
    n_cmp = 0; n_err = 0;
    rst_pat = {W'(0), W'(0), W'(0), 2'd0, 2'd1, 2'd2};
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_res", 64'(observed()), 64'(rst_pat));
    check("reset_ov", 64'(out_valid), 64'd0);
    held = rst_pat;
    #2 rst_n = 1'b1;

    step("distinct", 1'b1, 7'd36, 7'd9, 7'd99);
    step("perm0", 1'b1, 7'd5,   7'd60,  7'd120);
    step("perm1", 1'b1, 7'd5,   7'd120, 7'd60);
    step("perm2", 1'b1, 7'd60,  7'd5,   7'd120);
    step("perm3", 1'b1, 7'd60,  7'd120, 7'd5);
    step("perm4", 1'b1, 7'd120, 7'd5,   7'd60);
    step("perm5", 1'b1, 7'd120, 7'd60,  7'd5);
    step("all_eq", 1'b1, 7'd9, 7'd9, 7'd9);
    step("tie_ac", 1'b1, 7'd20, 7'd7, 7'd20);
    step("extreme", 1'b1, 7'd127, 7'd0, 7'd127);
    step("tie_ab", 1'b1, 7'd50, 7'd50, 7'd3);
    step("tie_bc", 1'b1, 7'd0, 7'd127, 7'd127);
    for (int i = 0; i < 3; i++) step("hold", 1'b0, rnd_val(), rnd_val(), rnd_val());

    // reset between edges while out_valid is high and a new triple is presented
    step("pre_rst", 1'b1, 7'd1, 7'd2, 7'd3);
    in_valid = 1'b1; a = 7'd100; b = 7'd50; c = 7'd25;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_res", 64'(observed()), 64'(rst_pat));
    check("async_rst_ov", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("rst_discard_res", 64'(observed()), 64'(rst_pat));
    check("rst_discard_ov", 64'(out_valid), 64'd0);
    held = rst_pat;
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    step("post_rst", 1'b1, 7'd100, 7'd50, 7'd25);

    for (int i = 0; i < 500; i++) begin
      rx = rnd_val(); ry = rnd_val(); rz = rnd_val();
      if ($urandom_range(0, 3) == 0) ry = rx;
      step("rand", ($urandom_range(0, 3) != 0), rx, ry, rz);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
